// File: rtl/dmem_responder_if.sv
// Data-port bundle between the core and dmem_responder, including the outbound TX byte stream.
// master: core/consumer side; slave: responder side.
interface dmem_responder_if;
    logic [31:0] daddr;
    logic [31:0] ddata_w;
    logic        d_w;
    logic        d_r;
    logic [31:0] ddata_r;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output daddr, ddata_w, d_w, d_r, tx_ready,
        input  ddata_r, leds, tx_data, tx_valid
    );

    modport slave (
        input  daddr, ddata_w, d_w, d_r, tx_ready,
        output ddata_r, leds, tx_data, tx_valid
    );
endinterface

// File: rtl/dmem_responder.sv
// Zero-wait-state data-side responder: word RAM, I/O registers and an outbound byte FIFO.
// Optional ACCESS_ERR_EN adds a saturating access-error counter at I/O offset 0x14.
module dmem_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h8000_0000
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    localparam logic [7:0] OFF_CYCLE  = 8'h00;
    localparam logic [7:0] OFF_LEDS   = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;
    localparam logic [7:0] OFF_CLR    = 8'h10;
`ifdef ACCESS_ERR_EN
    localparam logic [7:0] OFF_ERR    = 8'h14;
`endif

    logic [31:0]   ram [DEPTH];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic [31:0]   cycle_q;
    logic [7:0]    leds_q;
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    logic          ram_sel, io_hit, io_listed, illegal;
    logic [7:0]    io_off;
    logic [AW-1:0] ram_idx;
    logic          fifo_empty, fifo_full;
    logic          push_req, push_ok, push_drop, pop;
    logic [31:0]   status;
    logic [31:0]   rd_val;

    // RAM wins if the I/O window is ever configured to overlap it.
    assign ram_sel = bus.daddr < RAM_BYTES;
    assign io_hit  = !ram_sel && (bus.daddr[31:8] == IO_BASE[31:8]);
    assign illegal = !ram_sel && !io_hit;
    assign io_off  = {bus.daddr[7:2], 2'b00};
    assign ram_idx = bus.daddr[AW+1:2];

`ifdef ACCESS_ERR_EN
    assign io_listed = io_off inside {OFF_CYCLE, OFF_LEDS, OFF_TXDATA, OFF_STATUS, OFF_CLR,
                                      OFF_ERR};
`else
    assign io_listed = io_off inside {OFF_CYCLE, OFF_LEDS, OFF_TXDATA, OFF_STATUS, OFF_CLR};
`endif

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && bus.tx_ready;
    assign push_req   = bus.d_w && io_hit && (io_off == OFF_TXDATA);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign push_drop  = push_req && fifo_full && !pop;

    assign status = {21'b0, ovf_q, fifo_full, fifo_empty, 8'(count_q)};

`ifdef ACCESS_ERR_EN
    logic [15:0] err_cnt_q;
    logic        err_clr, err_inc;

    assign err_clr = bus.d_w && io_hit && (io_off == OFF_ERR);
    assign err_inc = ((bus.d_r || bus.d_w) && (illegal || (io_hit && !io_listed))) || push_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
`endif

    always_comb begin
        rd_val = '0;
        if (ram_sel) begin
            rd_val = ram[ram_idx];
        end else if (io_hit) begin
            case (io_off)
                OFF_CYCLE:  rd_val = cycle_q;
                OFF_LEDS:   rd_val = {24'b0, leds_q};
                OFF_STATUS: rd_val = status;
`ifdef ACCESS_ERR_EN
                OFF_ERR:    rd_val = {16'b0, err_cnt_q};
`endif
                default:    rd_val = '0;
            endcase
        end else begin
            rd_val = 32'hDEAD_BEEF;
        end
    end

    assign bus.ddata_r  = bus.d_r ? rd_val : '0;
    assign bus.leds     = leds_q;
    assign bus.tx_valid = !fifo_empty;
    assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_q];

    // RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (bus.d_w && ram_sel) begin
            ram[ram_idx] <= bus.ddata_w;
        end
    end

    // Storage is not reset; the pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            fifo_mem[wr_ptr_q] <= bus.ddata_w[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q  <= '0;
            leds_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (bus.d_w && io_hit && (io_off == OFF_LEDS)) begin
                leds_q <= bus.ddata_w[7:0];
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - CW'(1);
            end
            if (bus.d_w && io_hit && (io_off == OFF_CLR)) begin
                ovf_q <= 1'b0;
            end else if (push_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: RAM, reset, FIFO overflow and
// push/pop-when-full, CYCLE counter, illegal access and (when built with it) ACCESS_ERR_EN.
module tb_dmem_responder;

    localparam logic [31:0] IO     = 32'h8000_0000;
    localparam logic [31:0] CYC    = IO + 32'h00;
    localparam logic [31:0] LEDS   = IO + 32'h04;
    localparam logic [31:0] TXD    = IO + 32'h08;
    localparam logic [31:0] STATUS = IO + 32'h0C;
    localparam logic [31:0] CLR    = IO + 32'h10;
    localparam logic [31:0] ERRC   = IO + 32'h14;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH      (1024),
        .FIFO_DEPTH (8),
        .IO_BASE    (32'h8000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.daddr   = a;
        bus.ddata_w = d;
        bus.d_w     = 1'b1;
        @(posedge clk);
        #1;
        bus.d_w = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.daddr = a;
        bus.d_r   = 1'b1;
        #3;
        d = bus.ddata_r;
        @(posedge clk);
        #1;
        bus.d_r = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset        = 1'b1;
        bus.daddr    = 32'h40;
        bus.ddata_w  = '0;
        bus.d_w      = 1'b0;
        bus.d_r      = 1'b0;
        bus.tx_ready = 1'b0;
        idle(2);
        checks++;
        if (bus.leds !== 8'h00) begin
            errors++;
            $display("FAIL reset_leds: got %h want 00", bus.leds);
        end
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx: got valid=%b data=%h want 0/00", bus.tx_valid, bus.tx_data);
        end
        checks++;
        if (bus.ddata_r !== 32'h0) begin
            errors++;
            $display("FAIL reset_ddata_r: got %h want 00000000", bus.ddata_r);
        end
        reset = 1'b0;
        rd(STATUS, v);
        checks++;
        if (v !== 32'h100) begin
            errors++;
            $display("FAIL reset_status: got %h want 00000100", v);
        end
    endtask

    task automatic test_ram();
        logic [31:0] v;
        wr(32'h40, 32'h1234_5678);
        rd(32'h40, v);
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ram_rd: got %h want 12345678", v);
        end
        // Write and read together: read shows pre-write data.
        bus.daddr   = 32'h40;
        bus.ddata_w = 32'hAAAA_AAAA;
        bus.d_w     = 1'b1;
        bus.d_r     = 1'b1;
        #3;
        v = bus.ddata_r;
        @(posedge clk);
        #1;
        bus.d_w = 1'b0;
        bus.d_r = 1'b0;
        checks++;
        if (v !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ram_rw_old: got %h want 12345678", v);
        end
        rd(32'h40, v);
        checks++;
        if (v !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL ram_rw_new: got %h want aaaaaaaa", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(LEDS, 32'h5A);
        wr(TXD, 32'h11);
        wr(TXD, 32'h22);
        wr(TXD, 32'h33);
        checks++;
        if (bus.leds !== 8'h5A || bus.tx_data !== 8'h11 || bus.tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: got leds=%h head=%h valid=%b want 5a/11/1",
                     bus.leds, bus.tx_data, bus.tx_valid);
        end
        idle(2);
        // Push and pop attempted in the reset cycle must both be ignored.
        reset        = 1'b1;
        bus.daddr    = TXD;
        bus.ddata_w  = 32'h44;
        bus.d_w      = 1'b1;
        bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.d_w      = 1'b0;
        bus.tx_ready = 1'b0;
        checks++;
        if (bus.leds !== 8'h00 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got leds=%h valid=%b head=%h want 00/0/00",
                     bus.leds, bus.tx_valid, bus.tx_data);
        end
        rd(STATUS, v);
        checks++;
        if (v !== 32'h100) begin
            errors++;
            $display("FAIL mid_reset_status: got %h want 00000100", v);
        end
        rd(32'h40, v);
        checks++;
        if (v !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL ram_kept: got %h want aaaaaaaa", v);
        end
    endtask

    task automatic test_fifo_full();
        logic [31:0] v;
        bus.tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wr(TXD, 32'(i));
        end
        rd(STATUS, v);
        checks++;
        if (v !== 32'h208) begin
            errors++;
            $display("FAIL full_status: got %h want 00000208", v);
        end
        wr(TXD, 32'h09);
        rd(STATUS, v);
        checks++;
        if (v !== 32'h608 || bus.tx_data !== 8'h01) begin
            errors++;
            $display("FAIL ovf: got status=%h head=%h want 00000608/01", v, bus.tx_data);
        end
        wr(CLR, 32'h0);
        rd(STATUS, v);
        checks++;
        if (v !== 32'h208) begin
            errors++;
            $display("FAIL ovf_clr: got %h want 00000208", v);
        end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] v;
        logic [7:0]  exp_q [8];
        logic [7:0]  head;
        exp_q = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        bus.daddr    = TXD;
        bus.ddata_w  = 32'h0A;
        bus.d_w      = 1'b1;
        bus.tx_ready = 1'b1;
        #3;
        head = bus.tx_data;
        @(posedge clk);
        #1;
        bus.d_w      = 1'b0;
        bus.tx_ready = 1'b0;
        checks++;
        if (head !== 8'h01) begin
            errors++;
            $display("FAIL pp_popped: got %h want 01", head);
        end
        rd(STATUS, v);
        checks++;
        if (v !== 32'h208) begin
            errors++;
            $display("FAIL pp_status: got %h want 00000208", v);
        end
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #3;
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_q[i]) begin
                errors++;
                $display("FAIL drain[%0d]: got valid=%b data=%h want 1/%h",
                         i, bus.tx_valid, bus.tx_data, exp_q[i]);
            end
            @(posedge clk);
            #1;
        end
        bus.tx_ready = 1'b0;
        rd(STATUS, v);
        checks++;
        if (v !== 32'h100 || bus.tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained: got status=%h valid=%b want 00000100/0", v, bus.tx_valid);
        end
    endtask

    task automatic test_io_regs();
        logic [31:0] a, b, v;
        rd(CYC, a);
        idle(4);
        rd(CYC, b);
        checks++;
        if (b - a !== 32'd5) begin
            errors++;
            $display("FAIL cycle_delta: got %0d want 5", b - a);
        end
        wr(LEDS, 32'hFFFF_FFA5);
        rd(LEDS, v);
        checks++;
        if (v !== 32'hA5 || bus.leds !== 8'hA5) begin
            errors++;
            $display("FAIL leds_rd: got %h port=%h want 000000a5/a5", v, bus.leds);
        end
        rd(TXD, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL txdata_rd: got %h want 00000000", v);
        end
        wr(32'h4000_0000, 32'h1);
        rd(32'h4000_0000, v);
        checks++;
        if (v !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL illegal_rd: got %h want deadbeef", v);
        end
        bus.daddr = 32'h40;
        #3;
        checks++;
        if (bus.ddata_r !== 32'h0) begin
            errors++;
            $display("FAIL no_rd_zero: got %h want 00000000", bus.ddata_r);
        end
        idle(1);
    endtask

    task automatic test_access_err();
        logic [31:0] v;
`ifdef ACCESS_ERR_EN
        wr(ERRC, 32'h0);
        rd(32'h4000_0000, v);
        rd(ERRC, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL err_illegal: got %h want 00000001", v);
        end
        rd(IO + 32'h18, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL unlisted_rd: got %h want 00000000", v);
        end
        rd(ERRC, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL err_unlisted: got %h want 00000002", v);
        end
        wr(ERRC, 32'h0);
        rd(ERRC, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL err_clr: got %h want 00000000", v);
        end
`else
        rd(32'h4000_0000, v);
        rd(ERRC, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL err_absent: got %h want 00000000", v);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ram();
        test_reset_mid();
        test_fifo_full();
        test_push_pop_full();
        test_io_regs();
        test_access_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
